// File: rtl/axi4_mem_pkg.sv
// Shared types for the AXI4 burst memory: burst encodings, response codes,
// FSM state enums and the burst legality check.
package axi4_mem_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  // Reserved type, or WRAP with a length that does not give a power-of-two window.
  function automatic logic burst_invalid(input logic [1:0] burst, input logic [7:0] len);
    return (burst_e'(burst) == BURST_RSVD) ||
           ((burst_e'(burst) == BURST_WRAP) &&
            !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
  endfunction

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Next-beat byte address for FIXED / INCR / WRAP bursts (pure combinational).
module axi4_burst_addr_gen
  import axi4_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [7:0]            len_i,
  input  burst_e                burst_i,
  output logic [ADDR_WIDTH-1:0] next_addr_o
);

  localparam int BYTES = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] incrAddr;
  logic [ADDR_WIDTH-1:0] wrapMask;

  assign incrAddr = addr_i + ADDR_WIDTH'(BYTES);
  // Only meaningful for legal wrap lengths; illegal ones never touch memory.
  assign wrapMask = ADDR_WIDTH'((32'(len_i) + 32'd1) * 32'(BYTES) - 32'd1);

  always_comb begin
    next_addr_o = addr_i;
    case (burst_i)
      BURST_INCR: next_addr_o = incrAddr;
      BURST_WRAP: next_addr_o = (addr_i & ~wrapMask) | (incrAddr & wrapMask);
      default:    next_addr_o = addr_i;
    endcase
  end

endmodule

// File: rtl/axi4_burst_mem.sv
// AXI4 burst-capable memory slave with independent, concurrent read and write
// channels; bursts beyond MEM_DEPTH or of illegal shape answer SLVERR.
module axi4_burst_mem
  import axi4_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int MW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  function automatic logic inRange(input logic [ADDR_WIDTH-1:0] a);
    return 32'(a >> LSB) < 32'(MEM_DEPTH);
  endfunction

  function automatic logic [MW-1:0] wordIdx(input logic [ADDR_WIDTH-1:0] a);
    return MW'(a >> LSB);
  endfunction

  w_state_e              wstate_q;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [7:0]            wlen_q, wcnt_q;
  burst_e                wburst_q;
  logic                  winv_q, werr_q, wbeatErr, wfinal;
  logic                  awready_q, wready_q, bvalid_q;
  logic [1:0]            bresp_q;

  r_state_e              rstate_q;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d, rselAddr;
  logic [7:0]            rlen_q, rcnt_q;
  burst_e                rburst_q;
  logic                  rinv_q, rselInv, rselOk;
  logic                  arready_q, rvalid_q, rlast_q;
  logic [DATA_WIDTH-1:0] rdata_q, rbeatData;
  logic [1:0]            rresp_q, rbeatResp;

  axi4_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) uWrAddr (
    .addr_i(waddr_q), .len_i(wlen_q), .burst_i(wburst_q), .next_addr_o(waddr_d)
  );

  axi4_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) uRdAddr (
    .addr_i(raddr_q), .len_i(rlen_q), .burst_i(rburst_q), .next_addr_o(raddr_d)
  );

  assign wfinal   = (wcnt_q == wlen_q);
  assign wbeatErr = !inRange(waddr_q) || (wlast != wfinal);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      wburst_q  <= BURST_FIXED;
      winv_q    <= 1'b0;
      werr_q    <= 1'b0;
    end else begin
      case (wstate_q)
        W_IDLE: if (awvalid) begin
          wstate_q  <= W_DATA;
          awready_q <= 1'b0;
          wready_q  <= 1'b1;
          waddr_q   <= awaddr;
          wlen_q    <= awlen;
          wburst_q  <= burst_e'(awburst);
          wcnt_q    <= '0;
          winv_q    <= burst_invalid(awburst, awlen);
          werr_q    <= burst_invalid(awburst, awlen);
        end
        W_DATA: if (wvalid) begin
          waddr_q <= waddr_d;
          wcnt_q  <= wcnt_q + 8'd1;
          if (wbeatErr) werr_q <= 1'b1;
          if (wfinal) begin
            wstate_q <= W_RESP;
            wready_q <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= (werr_q || wbeatErr) ? RESP_SLVERR : RESP_OKAY;
          end
        end
        W_RESP: if (bready) begin
          wstate_q  <= W_IDLE;
          bvalid_q  <= 1'b0;
          awready_q <= 1'b1;
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  // Storage is deliberately left out of reset; only strobed lanes are touched.
  always_ff @(posedge clk) begin
    if (wstate_q == W_DATA && wvalid && !winv_q && inRange(waddr_q)) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wstrb[b]) mem[wordIdx(waddr_q)][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // In idle the first beat is fetched straight from the AR channel.
  assign rselAddr  = (rstate_q == R_IDLE) ? araddr : raddr_d;
  assign rselInv   = (rstate_q == R_IDLE) ? burst_invalid(arburst, arlen) : rinv_q;
  assign rselOk    = !rselInv && inRange(rselAddr);
  assign rbeatData = rselOk ? mem[wordIdx(rselAddr)] : '0;
  assign rbeatResp = rselOk ? RESP_OKAY : RESP_SLVERR;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      rburst_q  <= BURST_FIXED;
      rinv_q    <= 1'b0;
    end else begin
      case (rstate_q)
        R_IDLE: if (arvalid) begin
          rstate_q  <= R_DATA;
          arready_q <= 1'b0;
          raddr_q   <= araddr;
          rlen_q    <= arlen;
          rburst_q  <= burst_e'(arburst);
          rinv_q    <= rselInv;
          rcnt_q    <= '0;
          rvalid_q  <= 1'b1;
          rlast_q   <= (arlen == 8'd0);
          rdata_q   <= rbeatData;
          rresp_q   <= rbeatResp;
        end
        R_DATA: if (rready) begin
          if (rlast_q) begin
            rstate_q  <= R_IDLE;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            arready_q <= 1'b1;
          end else begin
            raddr_q <= raddr_d;
            rcnt_q  <= rcnt_q + 8'd1;
            rlast_q <= (rcnt_q + 8'd1 == rlen_q);
            rdata_q <= rbeatData;
            rresp_q <= rbeatResp;
          end
        end
      endcase
    end
  end

  // Address-ready lines read 0 while reset is held and 1 as soon as it drops.
  assign awready = awready_q & ~rst;
  assign arready = arready_q & ~rst;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

endmodule

// File: tb/tb_axi4_burst_mem.sv
// Randomised bench for axi4_burst_mem against an address-arithmetic memory model.
module tb_axi4_burst_mem;

  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [7:0]    awlen = '0, arlen = '0;
  logic [1:0]    awburst = '0, arburst = '0;
  logic          awvalid = 1'b0, wlast = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic          arvalid = 1'b0, rready = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          awready, wready, bvalid, arready, rlast, rvalid;
  logic [1:0]    bresp, rresp;
  logic [DW-1:0] rdata;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] mem_model [DEPTH];
  logic [31:0] wr_data [256];
  logic [3:0]  wr_strb [256];
  logic [31:0] rd_data [256], exp_data [256];
  logic [1:0]  rd_resp [256], exp_resp [256];
  logic        rd_last [256], exp_last [256];
  int          rd_n;

  axi4_burst_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awlen(awlen), .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic bit m_invalid(input logic [1:0] b, input logic [7:0] l);
    if (b == 2'd3) return 1'b1;
    if (b == 2'd2) return !(l == 1 || l == 3 || l == 7 || l == 15);
    return 1'b0;
  endfunction

  function automatic logic [15:0] m_next(input logic [15:0] a, input logic [7:0] l, input logic [1:0] b);
    int win, base, n;
    if (b == 2'd0) return a;
    if (b == 2'd1) return a + 16'd4;
    win  = (int'(l) + 1) * 4;
    base = (int'(a) / win) * win;
    n    = int'(a) + 4;
    if (n >= base + win) n = base;
    return 16'(n);
  endfunction

  function automatic logic wlast_for(input int mode, input int i, input int l);
    if (mode == 0) return (i == l);
    if (mode == 1) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_write(input logic [15:0] a, input logic [7:0] l, input logic [1:0] b,
                             input int mode, output logic [1:0] expResp);
    logic [15:0] cur = a;
    bit inv = m_invalid(b, l);
    bit err = inv;
    int idx;
    for (int i = 0; i <= int'(l); i++) begin
      idx = int'(cur) / 4;
      if (wlast_for(mode, i, int'(l)) != (i == int'(l))) err = 1;
      if (idx >= DEPTH) err = 1;
      else if (!inv)
        for (int k = 0; k < 4; k++)
          if (wr_strb[i][k]) mem_model[idx][8*k +: 8] = wr_data[i][8*k +: 8];
      cur = m_next(cur, l, b);
    end
    expResp = err ? 2'b10 : 2'b00;
  endtask

  task automatic model_read(input logic [15:0] a, input logic [7:0] l, input logic [1:0] b);
    logic [15:0] cur = a;
    bit inv = m_invalid(b, l);
    int idx;
    for (int i = 0; i <= int'(l); i++) begin
      idx = int'(cur) / 4;
      if (inv || idx >= DEPTH) begin
        exp_data[i] = '0; exp_resp[i] = 2'b10;
      end else begin
        exp_data[i] = mem_model[idx]; exp_resp[i] = 2'b00;
      end
      exp_last[i] = (i == int'(l));
      cur = m_next(cur, l, b);
    end
  endtask

  // ---------------- bus drivers ----------------
  task automatic do_write(input logic [15:0] a, input logic [7:0] l, input logic [1:0] b,
                          input int mode, output logic [1:0] resp);
    bit ok = 0;
    resp = 2'bxx;
    awaddr = a; awlen = l; awburst = b; awvalid = 1'b1;
    for (int cyc = 0; cyc < 100 && !ok; cyc++) begin
      @(negedge clk); if (awready) ok = 1;
      @(posedge clk); #1;
    end
    awvalid = 1'b0;
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL aw_timeout: got no awready want handshake");
      return;
    end
    for (int i = 0; i <= int'(l); i++) begin
      wdata = wr_data[i]; wstrb = wr_strb[i]; wlast = wlast_for(mode, i, int'(l)); wvalid = 1'b1;
      ok = 0;
      for (int cyc = 0; cyc < 100 && !ok; cyc++) begin
        @(negedge clk); if (wready) ok = 1;
        @(posedge clk); #1;
      end
      if (!ok) begin
        wvalid = 1'b0; n_cmp++; n_fail++;
        $display("[TB] FAIL w_timeout: got no wready at beat %0d want handshake", i);
        return;
      end
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    ok = 0;
    for (int cyc = 0; cyc < 100 && !ok; cyc++) begin
      @(negedge clk); if (bvalid) begin ok = 1; resp = bresp; end
      @(posedge clk); #1;
    end
    bready = 1'b0;
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL b_timeout: got no bvalid want response");
    end
  endtask

  task automatic ar_handshake(input logic [15:0] a, input logic [7:0] l, input logic [1:0] b);
    bit ok = 0;
    araddr = a; arlen = l; arburst = b; arvalid = 1'b1;
    for (int cyc = 0; cyc < 100 && !ok; cyc++) begin
      @(negedge clk); if (arready) ok = 1;
      @(posedge clk); #1;
    end
    arvalid = 1'b0;
    rd_n = 0;
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL ar_timeout: got no arready want handshake");
    end
  endtask

  task automatic collect_beats(input int upto, input bit rnd);
    for (int cyc = 0; cyc < 2000 && rd_n <= upto; cyc++) begin
      rready = rnd ? ($urandom % 3 != 0) : 1'b1;
      @(negedge clk);
      if (rvalid && rready) begin
        rd_data[rd_n] = rdata; rd_resp[rd_n] = rresp; rd_last[rd_n] = rlast; rd_n++;
      end
      @(posedge clk); #1;
    end
    rready = 1'b0;
    if (rd_n <= upto) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL r_timeout: got %0d beats want %0d", rd_n, upto + 1);
    end
  endtask

  task automatic do_read(input logic [15:0] a, input logic [7:0] l, input logic [1:0] b, input bit rnd);
    ar_handshake(a, l, b);
    collect_beats(int'(l), rnd);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b0) begin
      n_fail++; $display("[TB] FAIL reset_ctrl: got %b want 000000", {awready, arready, wready, bvalid, rvalid, rlast});
    end
    n_cmp++;
    if ({bresp, rresp, rdata} !== '0) begin
      n_fail++; $display("[TB] FAIL reset_data: got %h/%h/%h want 0/0/0", bresp, rresp, rdata);
    end
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if ({awready, arready, wready, bvalid, rvalid} !== 5'b11000) begin
      n_fail++; $display("[TB] FAIL reset_release: got %b want 11000", {awready, arready, wready, bvalid, rvalid});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    logic [1:0] e, g;
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 256; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'hF; end
      model_write(16'(blk * 1024), 8'd255, 2'd1, 0, e);
      do_write(16'(blk * 1024), 8'd255, 2'd1, 0, g);
      n_cmp++;
      if (g !== e) begin n_fail++; $display("[TB] FAIL fill_bresp blk %0d: got %0d want %0d", blk, g, e); end
    end
  endtask

  task automatic test_incr();
    logic [1:0] e, g;
    for (int i = 0; i < 4; i++) begin wr_data[i] = 32'h11111111 * (i + 1); wr_strb[i] = 4'hF; end
    model_write(16'h0010, 8'd3, 2'd1, 0, e);
    do_write(16'h0010, 8'd3, 2'd1, 0, g);
    n_cmp++;
    if (g !== 2'b00) begin n_fail++; $display("[TB] FAIL incr_bresp: got %0d want 0", g); end
    model_read(16'h0010, 8'd3, 2'd1);
    do_read(16'h0010, 8'd3, 2'd1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rd_data[i] !== 32'h11111111 * (i + 1) || rd_resp[i] !== 2'b00 || rd_last[i] !== (i == 3)) begin
        n_fail++;
        $display("[TB] FAIL incr_beat %0d: got %h/%0d/%b want %h/0/%b", i, rd_data[i], rd_resp[i], rd_last[i],
                 32'h11111111 * (i + 1), (i == 3));
      end
    end
  endtask

  task automatic test_wrap();
    int words [4] = '{14, 15, 12, 13};
    do_read(16'h0038, 8'd3, 2'd2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rd_data[i] !== mem_model[words[i]] || rd_resp[i] !== 2'b00) begin
        n_fail++;
        $display("[TB] FAIL wrap_beat %0d: got %h/%0d want %h/0", i, rd_data[i], rd_resp[i], mem_model[words[i]]);
      end
    end
  endtask

  task automatic test_fixed_strobes();
    logic [1:0] e, g;
    wr_data[0] = 32'h000000AA; wr_strb[0] = 4'h1;
    wr_data[1] = 32'h0000BB00; wr_strb[1] = 4'h2;
    wr_data[2] = 32'h00CC0000; wr_strb[2] = 4'h4;
    wr_data[3] = 32'hDD000000; wr_strb[3] = 4'h8;
    model_write(16'h0004, 8'd3, 2'd0, 0, e);
    do_write(16'h0004, 8'd3, 2'd0, 0, g);
    do_read(16'h0004, 8'd0, 2'd1, 1'b0);
    n_cmp++;
    if (rd_data[0] !== 32'hDDCCBBAA || g !== 2'b00) begin
      n_fail++; $display("[TB] FAIL fixed_strobe: got %h/%0d want ddccbbaa/0", rd_data[0], g);
    end
  endtask

  task automatic test_boundary();
    logic [1:0] e, g;
    wr_data[0] = $urandom; wr_data[1] = $urandom; wr_strb[0] = 4'hF; wr_strb[1] = 4'hF;
    model_write(16'h0FFC, 8'd1, 2'd1, 0, e);
    do_write(16'h0FFC, 8'd1, 2'd1, 0, g);
    n_cmp++;
    if (g !== 2'b10) begin n_fail++; $display("[TB] FAIL oor_bresp: got %0d want 2", g); end
    model_read(16'h0FFC, 8'd1, 2'd1);
    do_read(16'h0FFC, 8'd1, 2'd1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (rd_data[i] !== exp_data[i] || rd_resp[i] !== exp_resp[i]) begin
        n_fail++; $display("[TB] FAIL oor_read %0d: got %h/%0d want %h/%0d", i, rd_data[i], rd_resp[i], exp_data[i], exp_resp[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'hF; end
    model_write(16'h0040, 8'd2, 2'd2, 0, e);
    do_write(16'h0040, 8'd2, 2'd2, 0, g);
    n_cmp++;
    if (g !== 2'b10) begin n_fail++; $display("[TB] FAIL badwrap_bresp: got %0d want 2", g); end
    model_read(16'h0040, 8'd2, 2'd1);
    do_read(16'h0040, 8'd2, 2'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (rd_data[i] !== exp_data[i]) begin
        n_fail++; $display("[TB] FAIL badwrap_unchanged %0d: got %h want %h", i, rd_data[i], exp_data[i]);
      end
    end
    do_read(16'h0040, 8'd2, 2'd2, 1'b0);
    n_cmp++;
    if ({rd_data[0], rd_resp[0], rd_resp[2], rd_last[2]} !== {32'h0, 2'b10, 2'b10, 1'b1}) begin
      n_fail++; $display("[TB] FAIL badwrap_read: got %h/%0d/%0d/%b want 0/2/2/1", rd_data[0], rd_resp[0], rd_resp[2], rd_last[2]);
    end
    for (int m = 1; m <= 2; m++) begin
      for (int i = 0; i < 3; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'hF; end
      model_write(16'h0200, 8'd2, 2'd1, m, e);
      do_write(16'h0200, 8'd2, 2'd1, m, g);
      n_cmp++;
      if (g !== e) begin n_fail++; $display("[TB] FAIL wlast_mode%0d: got %0d want %0d", m, g, e); end
    end
  endtask

  task automatic test_rready_stall();
    logic [37:0] hold;
    model_read(16'h0100, 8'd7, 2'd1);
    ar_handshake(16'h0100, 8'd7, 2'd1);
    collect_beats(1, 1'b0);
    @(negedge clk);
    hold = {rvalid, rlast, rresp, rdata};
    n_cmp++;
    if (hold !== {1'b1, exp_last[2], exp_resp[2], exp_data[2]}) begin
      n_fail++; $display("[TB] FAIL stall_present: got %h want %h", hold, {1'b1, exp_last[2], exp_resp[2], exp_data[2]});
    end
    for (int s = 0; s < 2; s++) begin
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if ({rvalid, rlast, rresp, rdata} !== hold) begin
        n_fail++; $display("[TB] FAIL stall_hold %0d: got %h want %h", s, {rvalid, rlast, rresp, rdata}, hold);
      end
    end
    @(posedge clk); #1;
    collect_beats(7, 1'b0);
    for (int i = 2; i < 8; i++) begin
      n_cmp++;
      if ({rd_data[i], rd_resp[i], rd_last[i]} !== {exp_data[i], exp_resp[i], exp_last[i]}) begin
        n_fail++; $display("[TB] FAIL stall_beat %0d: got %h want %h", i, rd_data[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    ar_handshake(16'h0100, 8'd7, 2'd1);
    collect_beats(1, 1'b0);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({rvalid, rlast, arready, awready, rdata} !== '0) begin
      n_fail++; $display("[TB] FAIL midreset_async: got %b%b%b%b/%h want 0000/0", rvalid, rlast, arready, awready, rdata);
    end
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if ({arready, awready, rvalid} !== 3'b110) begin
      n_fail++; $display("[TB] FAIL midreset_release: got %b want 110", {arready, awready, rvalid});
    end
    @(posedge clk); #1;
    model_read(16'h0100, 8'd3, 2'd1);
    do_read(16'h0100, 8'd3, 2'd1, 1'b0);
    n_cmp++;
    if ({rd_data[3], rd_last[3]} !== {exp_data[3], 1'b1}) begin
      n_fail++; $display("[TB] FAIL midreset_after: got %h want %h", rd_data[3], exp_data[3]);
    end
  endtask

  task automatic test_concurrent();
    logic [1:0] e, g;
    for (int i = 0; i < 8; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'($urandom); end
    model_read(16'h0400, 8'd7, 2'd1);
    model_write(16'h0800, 8'd7, 2'd1, 0, e);
    fork
      do_write(16'h0800, 8'd7, 2'd1, 0, g);
      do_read(16'h0400, 8'd7, 2'd1, 1'b1);
    join
    n_cmp++;
    if (g !== e) begin n_fail++; $display("[TB] FAIL conc_bresp: got %0d want %0d", g, e); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if ({rd_data[i], rd_resp[i], rd_last[i]} !== {exp_data[i], exp_resp[i], exp_last[i]}) begin
        n_fail++; $display("[TB] FAIL conc_beat %0d: got %h want %h", i, rd_data[i], exp_data[i]);
      end
    end
    model_read(16'h0800, 8'd7, 2'd1);
    do_read(16'h0800, 8'd7, 2'd1, 1'b0);
    n_cmp++;
    if (rd_data[5] !== exp_data[5]) begin
      n_fail++; $display("[TB] FAIL conc_written: got %h want %h", rd_data[5], exp_data[5]);
    end
  endtask

  task automatic pick_burst(output logic [15:0] a, output logic [7:0] l, output logic [1:0] b);
    int lens [4] = '{1, 3, 7, 15};
    int r = $urandom % 10;
    b = (r < 4) ? 2'd1 : (r < 7) ? 2'd2 : (r < 9) ? 2'd0 : 2'd3;
    if (b == 2'd2) l = ($urandom % 6 == 0) ? 8'($urandom % 16) : 8'(lens[$urandom % 4]);
    else           l = 8'($urandom % 16);
    a = 16'(($urandom % 1040) * 4);
  endtask

  task automatic test_random();
    logic [15:0] a; logic [7:0] l; logic [1:0] b, e, g;
    int mode;
    for (int it = 0; it < 30; it++) begin
      pick_burst(a, l, b);
      for (int i = 0; i < 16; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'($urandom); end
      mode = ($urandom % 8 == 0) ? 1 + int'($urandom % 2) : 0;
      model_write(a, l, b, mode, e);
      do_write(a, l, b, mode, g);
      n_cmp++;
      if (g !== e) begin n_fail++; $display("[TB] FAIL rand_bresp it %0d: got %0d want %0d", it, g, e); end
      pick_burst(a, l, b);
      model_read(a, l, b);
      do_read(a, l, b, 1'b1);
      for (int i = 0; i <= int'(l); i++) begin
        n_cmp++;
        if ({rd_data[i], rd_resp[i], rd_last[i]} !== {exp_data[i], exp_resp[i], exp_last[i]}) begin
          n_fail++;
          $display("[TB] FAIL rand_read it %0d beat %0d: got %h/%0d/%b want %h/%0d/%b", it, i,
                   rd_data[i], rd_resp[i], rd_last[i], exp_data[i], exp_resp[i], exp_last[i]);
        end
      end
    end
  endtask

  initial begin
    $display("[TB] starting axi4_burst_mem bench");
    test_reset();
    test_fill();
    test_incr();
    test_wrap();
    test_fixed_strobes();
    test_boundary();
    test_rready_stall();
    test_reset_mid_read();
    test_concurrent();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
